dqsw_delay_training_ctrl: RTL and testbench
===========================================

Name: dqsw_delay_training_ctrl

Overview:
Sequencer for one LPDDR3 lane's DQSW270 training IOD. It sweeps the IOD dynamic delay line through DELAY_LINE_LOAD, MOVE and DIRECTION, and samples the eye-monitor EARLY/LATE flags after each step. It locates the first tap where the strobe reads late, then backs off by a programmable number of taps. It sits between the lane training FSM and the per-lane IOD and runs entirely on FAB_CLK.

Parameters:
TAP_W, 8, width of the tap counter and of TAP_COUNT/EDGE_TAP.
MAX_TAPS, 128, number of delay taps swept before declaring failure (≤ 2^TAP_W).
SETTLE_CYCLES, 8, FAB_CLK cycles waited after a flag clear before sampling (≥1).
BACKOFF_TAPS, 2, reverse steps applied after the edge is found (< MAX_TAPS).

Ports:
FAB_CLK  in  1  fabric clock; every register uses the rising edge.
RESET_N  in  1  synchronous, active-low reset.
TRAIN_START  in  1  one-cycle start request.
TRAIN_BUSY  out  1  high from LOAD until DONE/ERR is entered.
TRAIN_DONE  out  1  sticky completion flag.
TRAIN_ERR  out  1  sticky failure flag, valid while TRAIN_DONE=1.
TAP_COUNT  out  TAP_W  current delay-line tap position as tracked by the block.
EDGE_TAP  out  TAP_W  tap at which the late edge was detected.
DELAY_LINE_LOAD  out  1  loads the reset delay value into the IOD.
DELAY_LINE_MOVE  out  1  one-cycle tap step pulse.
DELAY_LINE_DIRECTION  out  1  1 = increment, 0 = decrement; valid with MOVE.
DELAY_LINE_OUT_OF_RANGE  in  1  from the IOD.
EYE_MONITOR_CLEAR_FLAGS  out  1  one-cycle flag clear pulse.
EYE_MONITOR_EARLY  in  1  from the IOD.
EYE_MONITOR_LATE  in  1  from the IOD.

Behaviour:
- All outputs are registered. Reset (RESET_N=0 at a clock edge) forces state=IDLE and drives every output to 0, including TAP_COUNT and EDGE_TAP.
- Reset asserted mid-sweep aborts the sweep immediately. No reverse moves are issued; the IOD is re-LOADed on the next start.
- States: IDLE, LOAD, CLEAR, SETTLE, SAMPLE, STEP, GAP, BACKOFF, DONE, ERR.
- IDLE: when TRAIN_START=1, go to LOAD. TRAIN_START is ignored in every other state except DONE/ERR.
- LOAD: DELAY_LINE_LOAD=1 for exactly one cycle; TAP_COUNT←0; TRAIN_DONE/TRAIN_ERR←0; TRAIN_BUSY←1; next state CLEAR.
- CLEAR: EYE_MONITOR_CLEAR_FLAGS=1 for one cycle; settle counter←0; next state SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE (one cycle), evaluated in priority order:
  - LATE=1 and EARLY=0: edge found. EDGE_TAP←TAP_COUNT; go to BACKOFF.
  - Otherwise, if TAP_COUNT=MAX_TAPS-1: go to ERR.
  - Otherwise: go to STEP.
  - LATE=1 with EARLY=1 is treated as jitter (no edge) and the sweep continues.
- STEP: DELAY_LINE_MOVE=1 and DELAY_LINE_DIRECTION=1 for one cycle; TAP_COUNT+1 is registered in the same cycle; next state GAP.
- GAP: one idle cycle. MOVE is never high on two consecutive cycles.
  - If DELAY_LINE_OUT_OF_RANGE=1 in GAP, go to ERR.
  - Otherwise go to CLEAR.
- BACKOFF: issue BACKOFF_TAPS pulses of MOVE=1, DIRECTION=0, each followed by one gap cycle; TAP_COUNT decrements per pulse.
  - Saturation: if TAP_COUNT=0, stop issuing pulses early; this is not an error.
  - OUT_OF_RANGE=1 during a backoff gap cycle goes to ERR.
  - When finished, go to DONE.
  - BACKOFF_TAPS=0 goes straight to DONE.
- DONE: TRAIN_DONE=1, TRAIN_ERR=0, TRAIN_BUSY=0. Hold until TRAIN_START=1, which goes to LOAD and restarts training.
- ERR: TRAIN_DONE=1, TRAIN_ERR=1, TRAIN_BUSY=0; EDGE_TAP=0 if no edge was found. Hold until TRAIN_START, same as DONE.
- DELAY_LINE_DIRECTION holds its last value when MOVE=0. LOAD, MOVE and CLEAR are mutually exclusive in any cycle.
- Per-tap cost: 1 (CLEAR) + SETTLE_CYCLES + 1 (SAMPLE) + 2 (STEP, GAP) cycles.

Test Plan:
- Reset then idle: RESET_N low for 3 cycles then high, no start → all outputs 0 and no LOAD/MOVE/CLEAR pulses for 100 cycles.
- Nominal sweep, defaults: IOD model returns LATE=1, EARLY=0 from tap 10 onward → exactly one LOAD and 10 up-MOVE pulses; EDGE_TAP=10; 2 down-MOVEs; TAP_COUNT=8; TRAIN_DONE=1, TRAIN_ERR=0; sweep-to-DONE latency of 10×12+1+...+4 backoff cycles, checked exactly.
- No edge: LATE never asserts → 127 up-MOVEs; ERR with TRAIN_DONE=1, TRAIN_ERR=1, EDGE_TAP=0, TAP_COUNT=127.
- Out of range: model raises OUT_OF_RANGE after the 5th up-MOVE → ERR in the following GAP cycle; TAP_COUNT=5; no further MOVE pulses.
- Jitter and backoff saturation: EARLY=LATE=1 at tap 3, clean LATE at tap 1 with BACKOFF_TAPS=2.
  - With EARLY=LATE=1 at tap 3, the sweep continues past tap 3.
  - A clean LATE at tap 1 gives EDGE_TAP=1 and one down-MOVE only; TAP_COUNT=0; TRAIN_ERR=0.
- Mid-sweep reset and restart: RESET_N low at tap 6 → next cycle all outputs 0 with no down-MOVE. A new TRAIN_START reissues LOAD and sweeps again from tap 0. A TRAIN_START pulsed while BUSY is ignored, shown by no second LOAD.

Source files
------------

// File: rtl/dqsw_delay_training_ctrl.sv
// DQSW270 delay-line training sequencer for one LPDDR3 lane: sweeps the IOD tap
// upward until the eye monitor reads a clean LATE, then backs off a few taps.
module dqsw_delay_training_ctrl #(
  parameter int unsigned TAP_W         = 8,
  parameter int unsigned MAX_TAPS      = 128,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned BACKOFF_TAPS  = 2
) (
  input  logic             FAB_CLK,
  input  logic             RESET_N,
  input  logic             TRAIN_START,
  output logic             TRAIN_BUSY,
  output logic             TRAIN_DONE,
  output logic             TRAIN_ERR,
  output logic [TAP_W-1:0] TAP_COUNT,
  output logic [TAP_W-1:0] EDGE_TAP,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  input  logic             EYE_MONITOR_EARLY,
  input  logic             EYE_MONITOR_LATE
);

  localparam int unsigned SetW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned BkW  = (BACKOFF_TAPS < 1) ? 1 : $clog2(BACKOFF_TAPS + 1);

  localparam logic [TAP_W-1:0] LastTap = TAP_W'(MAX_TAPS - 1);
  localparam logic [TAP_W-1:0] TapOne  = TAP_W'(1);
  localparam logic [SetW-1:0]  SetLast = SetW'(SETTLE_CYCLES - 1);
  localparam logic [SetW-1:0]  SetOne  = SetW'(1);
  localparam logic [BkW-1:0]   BkLast  = BkW'(BACKOFF_TAPS);
  localparam logic [BkW-1:0]   BkOne   = BkW'(1);

  typedef enum logic [3:0] {
    StIdle, StLoad, StClear, StSettle, StSample, StStep, StGap, StBackoff, StDone, StErr
  } state_e;

  state_e            state_q, state_d;
  logic [TAP_W-1:0]  tap_q, tap_d;
  logic [TAP_W-1:0]  edge_q, edge_d;
  logic [SetW-1:0]   set_cnt_q, set_cnt_d;
  logic [BkW-1:0]    bk_cnt_q, bk_cnt_d;
  logic              bk_gap_q, bk_gap_d;
  logic              load_q, load_d;
  logic              move_q, move_d;
  logic              dir_q, dir_d;
  logic              clear_q, clear_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    edge_d    = edge_q;
    set_cnt_d = set_cnt_q;
    bk_cnt_d  = bk_cnt_q;
    bk_gap_d  = bk_gap_q;
    dir_d     = dir_q;
    move_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (TRAIN_START) state_d = StLoad;
      end
      StLoad: state_d = StClear;
      StClear: begin
        set_cnt_d = '0;
        state_d   = StSettle;
      end
      StSettle: begin
        if (set_cnt_q == SetLast) state_d = StSample;
        else                      set_cnt_d = set_cnt_q + SetOne;
      end
      StSample: begin
        // LATE together with EARLY is jitter around the edge, not the edge itself
        if (EYE_MONITOR_LATE && !EYE_MONITOR_EARLY) begin
          edge_d = tap_q;
          if (BACKOFF_TAPS == 0 || tap_q == '0) begin
            state_d = StDone;
          end else begin
            state_d  = StBackoff;
            bk_gap_d = 1'b0;
            bk_cnt_d = BkOne;
            tap_d    = tap_q - TapOne;
            move_d   = 1'b1;
            dir_d    = 1'b0;
          end
        end else if (tap_q == LastTap) begin
          state_d = StErr;
        end else begin
          state_d = StStep;
          tap_d   = tap_q + TapOne;
          move_d  = 1'b1;
          dir_d   = 1'b1;
        end
      end
      StStep: state_d = StGap;
      StGap: begin
        if (DELAY_LINE_OUT_OF_RANGE) state_d = StErr;
        else                         state_d = StClear;
      end
      StBackoff: begin
        // Alternates pulse and gap cycles; stops early once the tap saturates at 0
        if (!bk_gap_q) begin
          bk_gap_d = 1'b1;
        end else if (DELAY_LINE_OUT_OF_RANGE) begin
          state_d = StErr;
        end else if (bk_cnt_q == BkLast || tap_q == '0) begin
          state_d = StDone;
        end else begin
          bk_gap_d = 1'b0;
          bk_cnt_d = bk_cnt_q + BkOne;
          tap_d    = tap_q - TapOne;
          move_d   = 1'b1;
          dir_d    = 1'b0;
        end
      end
      StDone, StErr: begin
        if (TRAIN_START) state_d = StLoad;
      end
      default: state_d = StIdle;
    endcase

    load_d = (state_d == StLoad);
    if (load_d) begin
      tap_d  = '0;
      edge_d = '0;
    end
    clear_d = (state_d == StClear);
    busy_d  = !(state_d inside {StIdle, StDone, StErr});
    done_d  = (state_d inside {StDone, StErr});
    err_d   = (state_d == StErr);
  end

  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      state_q   <= StIdle;
      tap_q     <= '0;
      edge_q    <= '0;
      set_cnt_q <= '0;
      bk_cnt_q  <= '0;
      bk_gap_q  <= 1'b0;
      load_q    <= 1'b0;
      move_q    <= 1'b0;
      dir_q     <= 1'b0;
      clear_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      edge_q    <= edge_d;
      set_cnt_q <= set_cnt_d;
      bk_cnt_q  <= bk_cnt_d;
      bk_gap_q  <= bk_gap_d;
      load_q    <= load_d;
      move_q    <= move_d;
      dir_q     <= dir_d;
      clear_q   <= clear_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign TRAIN_BUSY              = busy_q;
  assign TRAIN_DONE              = done_q;
  assign TRAIN_ERR               = err_q;
  assign TAP_COUNT               = tap_q;
  assign EDGE_TAP                = edge_q;
  assign DELAY_LINE_LOAD         = load_q;
  assign DELAY_LINE_MOVE         = move_q;
  assign DELAY_LINE_DIRECTION    = dir_q;
  assign EYE_MONITOR_CLEAR_FLAGS = clear_q;

endmodule

// File: tb/tb_dqsw_delay_training_ctrl.sv
// Bench for dqsw_delay_training_ctrl: an IOD/eye-monitor model driven by the DUT's
// LOAD/MOVE pulses, with expected run results queued per scenario.
module tb_dqsw_delay_training_ctrl;

  localparam int unsigned TAP_W = 8;

  logic             FAB_CLK = 1'b0;
  logic             RESET_N = 1'b0;
  logic             TRAIN_START = 1'b0;
  logic             TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR;
  logic [TAP_W-1:0] TAP_COUNT, EDGE_TAP;
  logic             DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION;
  logic             DELAY_LINE_OUT_OF_RANGE, EYE_MONITOR_CLEAR_FLAGS;
  logic             EYE_MONITOR_EARLY, EYE_MONITOR_LATE;

  dqsw_delay_training_ctrl #(
    .TAP_W(TAP_W), .MAX_TAPS(128), .SETTLE_CYCLES(8), .BACKOFF_TAPS(2)
  ) dut (
    .FAB_CLK                 (FAB_CLK),
    .RESET_N                 (RESET_N),
    .TRAIN_START             (TRAIN_START),
    .TRAIN_BUSY              (TRAIN_BUSY),
    .TRAIN_DONE              (TRAIN_DONE),
    .TRAIN_ERR               (TRAIN_ERR),
    .TAP_COUNT               (TAP_COUNT),
    .EDGE_TAP                (EDGE_TAP),
    .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
    .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
    .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
    .EYE_MONITOR_CLEAR_FLAGS (EYE_MONITOR_CLEAR_FLAGS),
    .EYE_MONITOR_EARLY       (EYE_MONITOR_EARLY),
    .EYE_MONITOR_LATE        (EYE_MONITOR_LATE)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  typedef struct {
    logic err;
    int   edge_tap;
    int   tap;
    int   ups;
    int   downs;
    int   latency;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // IOD model knobs
  int late_from = 1000;
  int jitter_tap = 1000;
  int oor_after = 1000;

  int tb_tap = 0, ups_run = 0, downs_run = 0;
  int loads_total = 0, moves_total = 0, clears_total = 0, viol = 0;
  int cyc = 0, load_cyc = 0, done_cyc = 0;
  bit prev_move = 0, prev_done = 0;

  assign EYE_MONITOR_LATE        = (tb_tap >= late_from) || (tb_tap == jitter_tap);
  assign EYE_MONITOR_EARLY       = (tb_tap == jitter_tap);
  assign DELAY_LINE_OUT_OF_RANGE = (ups_run >= oor_after);

  always @(negedge FAB_CLK) begin
    int n;
    n = 0;
    cyc++;
    if (DELAY_LINE_LOAD === 1'b1) begin
      n++;
      loads_total++;
      tb_tap = 0; ups_run = 0; downs_run = 0;
      load_cyc = cyc;
    end
    if (DELAY_LINE_MOVE === 1'b1) begin
      n++;
      moves_total++;
      if (prev_move) viol++;
      if (DELAY_LINE_DIRECTION === 1'b1) begin tb_tap++; ups_run++; end
      else begin tb_tap--; downs_run++; end
    end
    if (EYE_MONITOR_CLEAR_FLAGS === 1'b1) begin n++; clears_total++; end
    if (n > 1) viol++;
    prev_move = (DELAY_LINE_MOVE === 1'b1);
    if (TRAIN_DONE === 1'b1 && !prev_done) done_cyc = cyc;
    prev_done = (TRAIN_DONE === 1'b1);
  end

  task automatic pulse_start();
    @(posedge FAB_CLK); #1 TRAIN_START = 1'b1;
    @(posedge FAB_CLK); #1 TRAIN_START = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (TRAIN_DONE === 1'b1) begin ok = 1; break; end
      @(posedge FAB_CLK); #1;
    end
    @(negedge FAB_CLK); #1;
  endtask

  task automatic test_reset();
    logic [22:0] outs;
    RESET_N = 1'b0;
    repeat (3) @(posedge FAB_CLK);
    #1;
    outs = {TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR, TAP_COUNT, EDGE_TAP, DELAY_LINE_LOAD,
            DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS};
    n_checks++;
    if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs got %h want 0", outs); end
    RESET_N = 1'b1;
    repeat (100) @(posedge FAB_CLK);
    #1;
    outs = {TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR, TAP_COUNT, EDGE_TAP, DELAY_LINE_LOAD,
            DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS};
    n_checks++;
    if (outs !== '0) begin n_fail++; $display("FAIL idle_outputs got %h want 0", outs); end
    n_checks++;
    if (loads_total + moves_total + clears_total !== 0) begin
      n_fail++;
      $display("FAIL idle_pulses got %0d want 0", loads_total + moves_total + clears_total);
    end
  endtask

  task automatic test_nominal();
    exp_t e;
    bit   ok;
    int   loads0;
    late_from = 10;
    exp_q.push_back('{err: 1'b0, edge_tap: 10, tap: 8, ups: 10, downs: 2, latency: 135});
    loads0 = loads_total;
    pulse_start();
    wait_done(400, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL nominal_timeout got done=%b want 1", TRAIN_DONE); end
    n_checks++;
    if (TRAIN_ERR !== e.err) begin n_fail++; $display("FAIL nominal_err got %b want %b", TRAIN_ERR, e.err); end
    n_checks++;
    if (int'(EDGE_TAP) !== e.edge_tap) begin n_fail++; $display("FAIL nominal_edge got %0d want %0d", EDGE_TAP, e.edge_tap); end
    n_checks++;
    if (int'(TAP_COUNT) !== e.tap) begin n_fail++; $display("FAIL nominal_tap got %0d want %0d", TAP_COUNT, e.tap); end
    n_checks++;
    if (ups_run !== e.ups || downs_run !== e.downs) begin
      n_fail++; $display("FAIL nominal_moves got up=%0d dn=%0d want up=%0d dn=%0d", ups_run, downs_run, e.ups, e.downs);
    end
    n_checks++;
    if (done_cyc - load_cyc !== e.latency) begin
      n_fail++; $display("FAIL nominal_latency got %0d want %0d", done_cyc - load_cyc, e.latency);
    end
    n_checks++;
    if (loads_total - loads0 !== 1) begin n_fail++; $display("FAIL nominal_loads got %0d want 1", loads_total - loads0); end
  endtask

  task automatic test_no_edge();
    exp_t e;
    bit   ok;
    late_from = 1000;
    exp_q.push_back('{err: 1'b1, edge_tap: 0, tap: 127, ups: 127, downs: 0, latency: 1535});
    pulse_start();
    wait_done(2000, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || TRAIN_ERR !== e.err) begin
      n_fail++; $display("FAIL noedge_err got done=%b err=%b want done=1 err=%b", TRAIN_DONE, TRAIN_ERR, e.err);
    end
    n_checks++;
    if (int'(EDGE_TAP) !== e.edge_tap) begin n_fail++; $display("FAIL noedge_edge got %0d want %0d", EDGE_TAP, e.edge_tap); end
    n_checks++;
    if (int'(TAP_COUNT) !== e.tap) begin n_fail++; $display("FAIL noedge_tap got %0d want %0d", TAP_COUNT, e.tap); end
    n_checks++;
    if (ups_run !== e.ups || downs_run !== e.downs) begin
      n_fail++; $display("FAIL noedge_moves got up=%0d dn=%0d want up=%0d dn=%0d", ups_run, downs_run, e.ups, e.downs);
    end
    n_checks++;
    if (done_cyc - load_cyc !== e.latency) begin
      n_fail++; $display("FAIL noedge_latency got %0d want %0d", done_cyc - load_cyc, e.latency);
    end
  endtask

  task automatic test_out_of_range();
    exp_t e;
    bit   ok;
    int   moves0;
    late_from = 1000;
    oor_after = 5;
    exp_q.push_back('{err: 1'b1, edge_tap: 0, tap: 5, ups: 5, downs: 0, latency: 61});
    pulse_start();
    wait_done(400, ok);
    e = exp_q.pop_front();
    moves0 = moves_total;
    repeat (30) @(posedge FAB_CLK);
    #1;
    n_checks++;
    if (!ok || TRAIN_ERR !== e.err) begin
      n_fail++; $display("FAIL oor_err got done=%b err=%b want done=1 err=%b", TRAIN_DONE, TRAIN_ERR, e.err);
    end
    n_checks++;
    if (int'(TAP_COUNT) !== e.tap) begin n_fail++; $display("FAIL oor_tap got %0d want %0d", TAP_COUNT, e.tap); end
    n_checks++;
    if (ups_run !== e.ups || moves_total !== moves0) begin
      n_fail++; $display("FAIL oor_moves got up=%0d extra=%0d want up=%0d extra=0", ups_run, moves_total - moves0, e.ups);
    end
    n_checks++;
    if (done_cyc - load_cyc !== e.latency) begin
      n_fail++; $display("FAIL oor_latency got %0d want %0d", done_cyc - load_cyc, e.latency);
    end
    oor_after = 1000;
  endtask

  task automatic test_jitter_saturation();
    exp_t e;
    bit   ok;
    jitter_tap = 3;
    late_from = 5;
    exp_q.push_back('{err: 1'b0, edge_tap: 5, tap: 3, ups: 5, downs: 2, latency: 75});
    pulse_start();
    wait_done(400, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || TRAIN_ERR !== e.err || int'(EDGE_TAP) !== e.edge_tap) begin
      n_fail++; $display("FAIL jitter_edge got err=%b edge=%0d want err=%b edge=%0d", TRAIN_ERR, EDGE_TAP, e.err, e.edge_tap);
    end
    n_checks++;
    if (int'(TAP_COUNT) !== e.tap || ups_run !== e.ups || done_cyc - load_cyc !== e.latency) begin
      n_fail++; $display("FAIL jitter_sweep got tap=%0d up=%0d lat=%0d want tap=%0d up=%0d lat=%0d",
                         TAP_COUNT, ups_run, done_cyc - load_cyc, e.tap, e.ups, e.latency);
    end

    jitter_tap = 1000;
    late_from = 1;
    exp_q.push_back('{err: 1'b0, edge_tap: 1, tap: 0, ups: 1, downs: 1, latency: 25});
    pulse_start();
    wait_done(400, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || TRAIN_ERR !== e.err || int'(EDGE_TAP) !== e.edge_tap) begin
      n_fail++; $display("FAIL sat_edge got err=%b edge=%0d want err=%b edge=%0d", TRAIN_ERR, EDGE_TAP, e.err, e.edge_tap);
    end
    n_checks++;
    if (int'(TAP_COUNT) !== e.tap) begin n_fail++; $display("FAIL sat_tap got %0d want %0d", TAP_COUNT, e.tap); end
    n_checks++;
    if (downs_run !== e.downs) begin n_fail++; $display("FAIL sat_downs got %0d want %0d", downs_run, e.downs); end
    n_checks++;
    if (done_cyc - load_cyc !== e.latency) begin
      n_fail++; $display("FAIL sat_latency got %0d want %0d", done_cyc - load_cyc, e.latency);
    end
  endtask

  task automatic test_midsweep_reset();
    exp_t        e;
    bit          ok;
    bit          hit;
    int          loads0;
    logic [22:0] outs;
    late_from = 1000;
    pulse_start();
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge FAB_CLK); #1;
      if (ups_run == 6) begin hit = 1; break; end
    end
    n_checks++;
    if (!hit) begin n_fail++; $display("FAIL midreset_reach got up=%0d want 6", ups_run); end
    RESET_N = 1'b0;
    @(posedge FAB_CLK); #1;
    outs = {TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR, TAP_COUNT, EDGE_TAP, DELAY_LINE_LOAD,
            DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS};
    n_checks++;
    if (outs !== '0) begin n_fail++; $display("FAIL midreset_outputs got %h want 0", outs); end
    repeat (2) @(posedge FAB_CLK);
    #1 RESET_N = 1'b1;
    repeat (3) @(posedge FAB_CLK);
    #1;
    n_checks++;
    if (downs_run !== 0) begin n_fail++; $display("FAIL midreset_downs got %0d want 0", downs_run); end

    late_from = 4;
    loads0 = loads_total;
    exp_q.push_back('{err: 1'b0, edge_tap: 4, tap: 2, ups: 4, downs: 2, latency: 63});
    pulse_start();
    n_checks++;
    if (DELAY_LINE_LOAD !== 1'b1 || TAP_COUNT !== '0) begin
      n_fail++; $display("FAIL restart_load got load=%b tap=%0d want load=1 tap=0", DELAY_LINE_LOAD, TAP_COUNT);
    end
    repeat (20) @(posedge FAB_CLK);
    pulse_start();
    wait_done(400, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (loads_total - loads0 !== 1) begin n_fail++; $display("FAIL busy_start_loads got %0d want 1", loads_total - loads0); end
    n_checks++;
    if (!ok || TRAIN_ERR !== e.err || int'(EDGE_TAP) !== e.edge_tap || int'(TAP_COUNT) !== e.tap) begin
      n_fail++; $display("FAIL restart_result got err=%b edge=%0d tap=%0d want err=%b edge=%0d tap=%0d",
                         TRAIN_ERR, EDGE_TAP, TAP_COUNT, e.err, e.edge_tap, e.tap);
    end
    n_checks++;
    if (ups_run !== e.ups || downs_run !== e.downs || done_cyc - load_cyc !== e.latency) begin
      n_fail++; $display("FAIL restart_sweep got up=%0d dn=%0d lat=%0d want up=%0d dn=%0d lat=%0d",
                         ups_run, downs_run, done_cyc - load_cyc, e.ups, e.downs, e.latency);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_no_edge();
    test_out_of_range();
    test_jitter_saturation();
    test_midsweep_reset();
    n_checks++;
    if (viol !== 0) begin n_fail++; $display("FAIL pulse_rules got %0d violations want 0", viol); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no completion want finish");
    $fatal(1, "timeout");
  end

endmodule
